// File: rtl/makestuff_ram_bw_if.sv
// Bus bundle for makestuff_ram_bw: clear/ready control, masked write port and read port.
// The master side drives requests; the slave side is the RAM.
interface makestuff_ram_bw_if #(
  parameter int unsigned ADDR_NBITS = 5,
  parameter int unsigned DATA_NBITS = 16,
  parameter int unsigned BYTE_NBITS = 8
);
  localparam int unsigned NLANES = DATA_NBITS / BYTE_NBITS;

  logic                  clear_in;
  logic                  ready_out;
  logic                  wrEnable_in;
  logic [NLANES-1:0]     wrMask_in;
  logic [ADDR_NBITS-1:0] wrAddr_in;
  logic [DATA_NBITS-1:0] wrData_in;
  logic                  rdEnable_in;
  logic [ADDR_NBITS-1:0] rdAddr_in;
  logic [DATA_NBITS-1:0] rdData_out;
  logic                  rdValid_out;
  logic                  parityErr_out;

  modport master (
    output clear_in, wrEnable_in, wrMask_in, wrAddr_in, wrData_in, rdEnable_in, rdAddr_in,
    input  ready_out, rdData_out, rdValid_out, parityErr_out
  );

  modport slave (
    input  clear_in, wrEnable_in, wrMask_in, wrAddr_in, wrData_in, rdEnable_in, rdAddr_in,
    output ready_out, rdData_out, rdValid_out, parityErr_out
  );
endinterface

// File: rtl/makestuff_ram_bw.sv
// Byte-writable RAM with a self-clearing sweep, 1- or 2-cycle pipelined reads.
// Optional per-lane even parity when MAKESTUFF_RAM_PARITY_EN is defined.
module makestuff_ram_bw #(
  parameter int unsigned ADDR_NBITS = 5,
  parameter int unsigned DATA_NBITS = 16,
  parameter int unsigned BYTE_NBITS = 8,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned RDW_MODE   = 0
) (
  input logic               clk_in,
  input logic               rstn_in,
  makestuff_ram_bw_if.slave bus
);
  localparam int unsigned NLANES = DATA_NBITS / BYTE_NBITS;
  localparam int unsigned DEPTH  = 2 ** ADDR_NBITS;

  if ((DATA_NBITS % BYTE_NBITS) != 0) begin : g_bad_lanes
    $error("DATA_NBITS must be a multiple of BYTE_NBITS");
  end
  if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
    $error("RD_LATENCY must be 1 or 2");
  end

  typedef logic [DATA_NBITS-1:0] row_t;
  typedef enum logic [0:0] {StClear, StReady} state_e;

  state_e                state_q;
  logic [ADDR_NBITS-1:0] cnt_q;
  logic                  ready_q;

  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      state_q <= StClear;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        StClear: begin
          if (bus.clear_in) begin
            cnt_q <= '0;
          end else if (cnt_q == '1) begin
            state_q <= StReady;
            ready_q <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + ADDR_NBITS'(1);
          end
        end
        StReady: begin
          if (bus.clear_in) begin
            state_q <= StClear;
            ready_q <= 1'b0;
            cnt_q   <= '0;
          end
        end
      endcase
    end
  end

  assign bus.ready_out = ready_q;

  logic wr_go, rd_go;
  assign wr_go = ready_q & bus.wrEnable_in;
  assign rd_go = ready_q & bus.rdEnable_in;

  row_t mem [DEPTH];

  always_ff @(posedge clk_in) begin
    if (rstn_in && !ready_q) begin
      mem[cnt_q] <= '0;
    end else if (wr_go) begin
      for (int i = 0; i < NLANES; i++) begin
        if (bus.wrMask_in[i]) begin
          mem[bus.wrAddr_in][i*BYTE_NBITS +: BYTE_NBITS] <= bus.wrData_in[i*BYTE_NBITS +: BYTE_NBITS];
        end
      end
    end
  end

`ifdef MAKESTUFF_RAM_PARITY_EN
  logic [NLANES-1:0] par_mem [DEPTH];

  always_ff @(posedge clk_in) begin
    if (rstn_in && !ready_q) begin
      par_mem[cnt_q] <= '0;
    end else if (wr_go) begin
      for (int i = 0; i < NLANES; i++) begin
        if (bus.wrMask_in[i]) begin
          par_mem[bus.wrAddr_in][i] <= ^bus.wrData_in[i*BYTE_NBITS +: BYTE_NBITS];
        end
      end
    end
  end
`endif

  // Capture value: pre-write row, with written lanes forwarded when RDW_MODE selects new data.
  row_t rd_row, cap_data;
  logic hit;
  logic cap_err;

  always_comb begin
    rd_row   = mem[bus.rdAddr_in];
    cap_data = rd_row;
    hit      = (RDW_MODE == 1) && wr_go && (bus.wrAddr_in == bus.rdAddr_in);
    cap_err  = 1'b0;
    for (int i = 0; i < NLANES; i++) begin
      if (hit && bus.wrMask_in[i]) begin
        cap_data[i*BYTE_NBITS +: BYTE_NBITS] = bus.wrData_in[i*BYTE_NBITS +: BYTE_NBITS];
      end
`ifdef MAKESTUFF_RAM_PARITY_EN
      else begin
        cap_err = cap_err |
                  ((^rd_row[i*BYTE_NBITS +: BYTE_NBITS]) ^ par_mem[bus.rdAddr_in][i]);
      end
`endif
    end
  end

  logic v1_q;
  row_t d1_q;

  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      v1_q <= 1'b0;
      d1_q <= '0;
    end else begin
      v1_q <= rd_go;
      if (rd_go) d1_q <= cap_data;
    end
  end

`ifdef MAKESTUFF_RAM_PARITY_EN
  logic e1_q;
  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) e1_q <= 1'b0;
    else          e1_q <= rd_go & cap_err;
  end
`else
  logic unused_cap_err;
  assign unused_cap_err    = cap_err;
  assign bus.parityErr_out = 1'b0;
`endif

  if (RD_LATENCY == 2) begin : g_lat2
    logic v2_q;
    row_t d2_q;
    always_ff @(posedge clk_in or negedge rstn_in) begin
      if (!rstn_in) begin
        v2_q <= 1'b0;
        d2_q <= '0;
      end else begin
        v2_q <= v1_q;
        if (v1_q) d2_q <= d1_q;
      end
    end
    assign bus.rdValid_out = v2_q;
    assign bus.rdData_out  = d2_q;
`ifdef MAKESTUFF_RAM_PARITY_EN
    logic e2_q;
    always_ff @(posedge clk_in or negedge rstn_in) begin
      if (!rstn_in) e2_q <= 1'b0;
      else          e2_q <= e1_q;
    end
    assign bus.parityErr_out = e2_q;
`endif
  end else begin : g_lat1
    assign bus.rdValid_out = v1_q;
    assign bus.rdData_out  = d1_q;
`ifdef MAKESTUFF_RAM_PARITY_EN
    assign bus.parityErr_out = e1_q;
`endif
  end
endmodule

// File: tb/tb_makestuff_ram_bw.sv
// Directed bench: three RAMs (defaults, new-data RDW, 2-cycle latency) share one stimulus stream.
module tb_makestuff_ram_bw;
  logic clk_in  = 1'b0;
  logic rstn_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int n_total = 0;
  int n_bad   = 0;

  makestuff_ram_bw_if #(.ADDR_NBITS(5), .DATA_NBITS(16), .BYTE_NBITS(8)) bus0 ();
  makestuff_ram_bw_if #(.ADDR_NBITS(5), .DATA_NBITS(16), .BYTE_NBITS(8)) bus1 ();
  makestuff_ram_bw_if #(.ADDR_NBITS(5), .DATA_NBITS(16), .BYTE_NBITS(8)) bus2 ();

  assign bus1.clear_in    = bus0.clear_in;
  assign bus1.wrEnable_in = bus0.wrEnable_in;
  assign bus1.wrMask_in   = bus0.wrMask_in;
  assign bus1.wrAddr_in   = bus0.wrAddr_in;
  assign bus1.wrData_in   = bus0.wrData_in;
  assign bus1.rdEnable_in = bus0.rdEnable_in;
  assign bus1.rdAddr_in   = bus0.rdAddr_in;
  assign bus2.clear_in    = bus0.clear_in;
  assign bus2.wrEnable_in = bus0.wrEnable_in;
  assign bus2.wrMask_in   = bus0.wrMask_in;
  assign bus2.wrAddr_in   = bus0.wrAddr_in;
  assign bus2.wrData_in   = bus0.wrData_in;
  assign bus2.rdEnable_in = bus0.rdEnable_in;
  assign bus2.rdAddr_in   = bus0.rdAddr_in;

  makestuff_ram_bw #(.RD_LATENCY(1), .RDW_MODE(0)) dut0 (
    .clk_in (clk_in), .rstn_in (rstn_in), .bus (bus0)
  );
  makestuff_ram_bw #(.RD_LATENCY(1), .RDW_MODE(1)) dut1 (
    .clk_in (clk_in), .rstn_in (rstn_in), .bus (bus1)
  );
  makestuff_ram_bw #(.RD_LATENCY(2), .RDW_MODE(0)) dut2 (
    .clk_in (clk_in), .rstn_in (rstn_in), .bus (bus2)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_wr(input logic en, input logic [4:0] a, input logic [15:0] d,
                        input logic [1:0] m);
    bus0.wrEnable_in = en;
    bus0.wrAddr_in   = a;
    bus0.wrData_in   = d;
    bus0.wrMask_in   = m;
  endtask

  task automatic set_rd(input logic en, input logic [4:0] a);
    bus0.rdEnable_in = en;
    bus0.rdAddr_in   = a;
  endtask

  task automatic write_row(input logic [4:0] a, input logic [15:0] d, input logic [1:0] m);
    set_wr(1'b1, a, d, m);
    tick();
    set_wr(1'b0, 5'd0, 16'h0, 2'b00);
  endtask

  task automatic read_chk(input string tag, input logic [4:0] a, input logic [15:0] exp,
                          input logic exp_perr);
    set_rd(1'b1, a);
    tick();
    set_rd(1'b0, 5'd0);
    check_eq({tag, "_valid"}, 32'(bus0.rdValid_out), 32'd1);
    check_eq({tag, "_data"}, 32'(bus0.rdData_out), 32'(exp));
    check_eq({tag, "_perr"}, 32'(bus0.parityErr_out), 32'(exp_perr));
  endtask

  task automatic wait_ready(input string tag, input int exp_n);
    int n = 0;
    while (!bus0.ready_out && n < 200) begin
      tick();
      n++;
    end
    check_eq(tag, 32'(n), 32'(exp_n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    bus0.clear_in = 1'b0;
    set_wr(1'b0, 5'd0, 16'h0, 2'b00);
    set_rd(1'b0, 5'd0);
    tick();
    tick();
    check_eq("rst_ready", 32'(bus0.ready_out), 32'd0);
    check_eq("rst_valid", 32'(bus0.rdValid_out), 32'd0);
    check_eq("rst_data", 32'(bus0.rdData_out), 32'd0);
    check_eq("rst_perr", 32'(bus0.parityErr_out), 32'd0);
    check_eq("rst_valid_l2", 32'(bus2.rdValid_out), 32'd0);

    rstn_in = 1'b1;
    wait_ready("sweep_len", 32);
    read_chk("rd0", 5'd0, 16'h0000, 1'b0);
    read_chk("rd17", 5'd17, 16'h0000, 1'b0);
    read_chk("rd31", 5'd31, 16'h0000, 1'b0);

    // Lane masking, including an all-zero mask.
    write_row(5'd5, 16'hABCD, 2'b11);
    write_row(5'd5, 16'h1200, 2'b10);
    write_row(5'd5, 16'hFFFF, 2'b00);
    read_chk("mask", 5'd5, 16'h12CD, 1'b0);
    tick();
    check_eq("hold_valid", 32'(bus0.rdValid_out), 32'd0);
    check_eq("hold_data", 32'(bus0.rdData_out), 32'h12CD);

    // Read-during-write, old vs new data.
    write_row(5'd3, 16'hAAAA, 2'b11);
    set_wr(1'b1, 5'd3, 16'h5555, 2'b11);
    set_rd(1'b1, 5'd3);
    tick();
    set_wr(1'b0, 5'd0, 16'h0, 2'b00);
    set_rd(1'b0, 5'd0);
    check_eq("rdw_old", 32'(bus0.rdData_out), 32'hAAAA);
    check_eq("rdw_new", 32'(bus1.rdData_out), 32'h5555);
    check_eq("rdw_l2_early", 32'(bus2.rdValid_out), 32'd0);
    tick();
    check_eq("rdw_l2_valid", 32'(bus2.rdValid_out), 32'd1);
    check_eq("rdw_l2_data", 32'(bus2.rdData_out), 32'hAAAA);

    set_wr(1'b1, 5'd3, 16'h1234, 2'b01);
    set_rd(1'b1, 5'd3);
    tick();
    set_wr(1'b0, 5'd0, 16'h0, 2'b00);
    set_rd(1'b0, 5'd0);
    check_eq("rdw_part_old", 32'(bus0.rdData_out), 32'h5555);
    check_eq("rdw_part_new", 32'(bus1.rdData_out), 32'h5534);

    // Pipelined reads with a later write and a clear in flight.
    write_row(5'd1, 16'h1111, 2'b11);
    write_row(5'd2, 16'h2222, 2'b11);
    write_row(5'd3, 16'h3333, 2'b11);
    set_rd(1'b1, 5'd1);
    tick();
    check_eq("pipe1_l1", 32'(bus0.rdData_out), 32'h1111);
    check_eq("pipe1_l2_valid", 32'(bus2.rdValid_out), 32'd0);
    set_rd(1'b1, 5'd2);
    set_wr(1'b1, 5'd1, 16'hDEAD, 2'b11);
    tick();
    check_eq("pipe2_l1", 32'(bus0.rdData_out), 32'h2222);
    check_eq("pipe2_l2_valid", 32'(bus2.rdValid_out), 32'd1);
    check_eq("pipe2_l2", 32'(bus2.rdData_out), 32'h1111);
    set_wr(1'b0, 5'd0, 16'h0, 2'b00);
    set_rd(1'b1, 5'd3);
    bus0.clear_in = 1'b1;
    tick();
    check_eq("pipe3_l1", 32'(bus0.rdData_out), 32'h3333);
    check_eq("pipe3_l2", 32'(bus2.rdData_out), 32'h2222);
    check_eq("pipe3_ready", 32'(bus0.ready_out), 32'd0);
    set_rd(1'b0, 5'd0);
    bus0.clear_in = 1'b0;
    tick();
    check_eq("pipe4_l2_valid", 32'(bus2.rdValid_out), 32'd1);
    check_eq("pipe4_l2", 32'(bus2.rdData_out), 32'h3333);
    check_eq("pipe4_l1_valid", 32'(bus0.rdValid_out), 32'd0);
    tick();
    check_eq("pipe5_l2_valid", 32'(bus2.rdValid_out), 32'd0);

    // Accesses during the sweep are ignored.
    set_rd(1'b1, 5'd0);
    set_wr(1'b1, 5'd0, 16'hBEEF, 2'b11);
    tick();
    set_rd(1'b0, 5'd0);
    set_wr(1'b0, 5'd0, 16'h0, 2'b00);
    check_eq("clr_no_read", 32'(bus0.rdValid_out), 32'd0);
    wait_ready("clr_len", 29);
    read_chk("clr_r0", 5'd0, 16'h0000, 1'b0);
    read_chk("clr_r1", 5'd1, 16'h0000, 1'b0);
    read_chk("clr_r5", 5'd5, 16'h0000, 1'b0);

    // clear_in during the sweep restarts it.
    bus0.clear_in = 1'b1;
    tick();
    bus0.clear_in = 1'b0;
    repeat (5) tick();
    bus0.clear_in = 1'b1;
    tick();
    bus0.clear_in = 1'b0;
    wait_ready("restart_len", 32);

    // Reset at sweep row 10 with held read data.
    write_row(5'd5, 16'h7777, 2'b11);
    read_chk("pre_rst", 5'd5, 16'h7777, 1'b0);
    bus0.clear_in = 1'b1;
    tick();
    bus0.clear_in = 1'b0;
    repeat (10) tick();
    rstn_in = 1'b0;
    #1;
    check_eq("arst_ready", 32'(bus0.ready_out), 32'd0);
    check_eq("arst_data", 32'(bus0.rdData_out), 32'd0);
    check_eq("arst_data_l2", 32'(bus2.rdData_out), 32'd0);
    tick();
    tick();
    rstn_in = 1'b1;
    wait_ready("rst_len", 32);

`ifdef MAKESTUFF_RAM_PARITY_EN
    write_row(5'd7, 16'h00FF, 2'b11);
    write_row(5'd8, 16'h00FF, 2'b11);
    dut0.mem[7][0] = ~dut0.mem[7][0];
    read_chk("par7", 5'd7, 16'h00FE, 1'b1);
    read_chk("par8", 5'd8, 16'h00FF, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/makestuff_ram_bw.md
MAKESTUFF_RAM_BW -- requirements
Module: makestuff_ram_bw

Interface
REQ-001 ADDR_NBITS, default 5, SHALL set the address width; depth = 2**ADDR_NBITS rows.
REQ-002 DATA_NBITS, default 16, SHALL set the row width in bits.
REQ-003 BYTE_NBITS, default 8, SHALL set the write-lane width; NLANES = DATA_NBITS/BYTE_NBITS.
REQ-004 RD_LATENCY, default 1, SHALL set the read latency in cycles; legal values are 1 and 2.
REQ-005 RDW_MODE, default 0, SHALL select read-during-write behaviour: 0 = old data, 1 = new data.
REQ-006 clk_in  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-007 rstn_in  input  1  SHALL be the asynchronous, active-low reset.
REQ-008 clear_in  input  1  SHALL request a zeroing sweep of the whole array.
REQ-009 ready_out  output  1  SHALL be high when the array accepts reads and writes.
REQ-010 wrEnable_in  input  1  SHALL be the write strobe.
REQ-011 wrMask_in  input  NLANES  SHALL select lanes to write; bit i covers data bits [i*BYTE_NBITS +: BYTE_NBITS].
REQ-012 wrAddr_in  input  ADDR_NBITS  SHALL be the write address.
REQ-013 wrData_in  input  DATA_NBITS  SHALL be the write data.
REQ-014 rdEnable_in  input  1  SHALL be the read strobe.
REQ-015 rdAddr_in  input  ADDR_NBITS  SHALL be the read address.
REQ-016 rdData_out  output  DATA_NBITS  SHALL carry read data.
REQ-017 rdValid_out  output  1  SHALL pulse high for one cycle per accepted read, aligned with rdData_out.
REQ-018 parityErr_out  output  1  SHALL flag a parity mismatch on the current read, aligned with rdValid_out.

Function
REQ-019 Elaboration SHALL fail if DATA_NBITS mod BYTE_NBITS is not 0, or if RD_LATENCY is not 1 or 2.
REQ-020 The FSM SHALL have two states, CLEAR and READY; ready_out = 1 only in READY.
REQ-021 In CLEAR, a counter SHALL start at 0 and write all-zero data (and zero parity) to one row per cycle.
REQ-022 After writing row 2**ADDR_NBITS-1, CLEAR SHALL go to READY; a full sweep takes exactly 2**ADDR_NBITS cycles.
REQ-023 clear_in in READY SHALL move the FSM to CLEAR with the counter at 0 on the next edge.
REQ-024 clear_in in CLEAR SHALL restart the counter at 0.
REQ-025 In CLEAR, wrEnable_in and rdEnable_in SHALL be ignored; no read is accepted and no user write lands.
REQ-026 In READY, wrEnable_in=1 SHALL update only the lanes with wrMask_in bit = 1; other lanes are kept.
REQ-027 A write with wrMask_in all-zero SHALL leave the row unchanged.
REQ-028 In READY, rdEnable_in=1 SHALL be accepted; rdValid_out and rdData_out follow exactly RD_LATENCY edges later.
REQ-029 Reads SHALL be fully pipelined: back-to-back accepted reads give back-to-back valid cycles.
REQ-030 rdData_out SHALL hold its last value while rdValid_out = 0.
REQ-031 For a same-cycle read and write to one address with RDW_MODE=0, rdData_out SHALL be the pre-write row.
REQ-032 With RDW_MODE=1, it SHALL be the merged row: written lanes from wrData_in, the rest from the pre-write row.
REQ-033 A write in any later cycle SHALL NOT alter data already captured for an in-flight read, including the RD_LATENCY=2 stage.
REQ-034 Reads accepted before a clear_in SHALL still complete with their captured data.

Reset
REQ-035 Asserting rstn_in SHALL immediately force ready_out=0, rdValid_out=0, rdData_out=0, parityErr_out=0, read pipeline empty, FSM=CLEAR, counter=0.
REQ-036 Array contents SHALL NOT be reset directly; the sweep that starts after reset releases SHALL zero them.
REQ-037 Reset asserted mid-sweep or mid-read SHALL abort the operation; the first cycle after release starts the sweep at row 0.

Configuration
REQ-038 With MAKESTUFF_RAM_PARITY_EN defined, each row SHALL store one even-parity bit per lane, written with its lane.
REQ-039 On each read, parity SHALL be checked per lane; parityErr_out=1 with rdValid_out if any lane mismatches.
REQ-040 Without MAKESTUFF_RAM_PARITY_EN, no parity storage or logic SHALL exist, and parityErr_out SHALL be tied to 0.

Verification
REQ-041 Reset, then ready_out is low for 32 cycles at defaults and then high; read of rows 0, 17 and 31 return 0x0000 with rdValid_out 1 cycle later.
REQ-042 Write 0xABCD to row 5 with mask 2'b11, then 0x1200 with mask 2'b10; the read of row 5 returns 0x12CD.
REQ-043 Same-cycle write 0x5555 and read of row 3 (holding 0xAAAA): RDW_MODE=0 returns 0xAAAA; RDW_MODE=1 returns 0x5555.
REQ-044 RD_LATENCY=2, reads of rows 1,2,3 on 3 consecutive cycles: valid on cycles +2,+3,+4 in order; clear_in mid-stream does not corrupt them.
REQ-045 Drop rstn_in at sweep row 10: ready_out is 0 at once; after release, ready_out rises exactly 32 cycles later.
REQ-046 With MAKESTUFF_RAM_PARITY_EN, force-flip one stored bit of row 7 and read it: parityErr_out=1 with rdValid_out; an unflipped row gives 0.
